branch_predictor_2bit: RTL
==========================

Name: branch_predictor_2bit

Overview:
- Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters, valid bits and partial tags.
- Successor to the 1-bit predictor: depth, tag width and counter width are parametrised; tagged hit detection, full table reset, synchronous table clear and saturating performance counters are added.
- Read is combinational in IF/ID; update is registered from EX/MEM resolution.

Parameters:
- DATA_WIDTH, 32, PC and target width.
- INDEX_BITS, 3, table depth = 2**INDEX_BITS entries.
- TAG_BITS, 8, partial tag width stored per entry.
- CNT_BITS, 2, direction counter width (min 2).
- PERF_WIDTH, 16, width of statistics counters.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_bp_clear  in  1  synchronous invalidate of all entries.
- if_id_opcode  in  7  opcode of instruction in IF/ID.
- if_pc  in  DATA_WIDTH  PC of instruction in IF/ID.
- ex_mem_opcode  in  7  opcode of resolving instruction.
- ex_mem_pc  in  DATA_WIDTH  PC of resolving instruction.
- ex_mem_branch_taken  in  1  resolved direction.
- ex_mem_branch_target  in  DATA_WIDTH  resolved target.
- ex_mem_predicted  in  1  prediction carried down the pipe for this branch.
- prediction  out  1  predict taken.
- branch_target  out  DATA_WIDTH  predicted target.
- bp_hit  out  1  valid tag match for a B-type in IF/ID.
- branch_count  out  PERF_WIDTH  resolved B-type count.
- mispredict_count  out  PERF_WIDTH  direction mispredict count.

Behaviour:
- Addressing:
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
  - pc[1:0] is ignored.
- Read (combinational):
  - bp_hit = (if_id_opcode==B_TYPE) & valid[idx] & (tag[idx]==if tag).
  - prediction = bp_hit & counter[idx] MSB.
  - branch_target = prediction ? target[idx] : 0.
- Update on a rising edge when ex_mem_opcode==B_TYPE and i_bp_clear=0:
  - Hit: counter increments if taken, decrements if not; saturates at all-ones and at 0. Target is written only when taken.
  - Miss (invalid or tag mismatch): allocate the entry. Set valid=1 and write the tag. Counter = WEAK_T (10..0) if taken, WEAK_NT (01..1) if not. Target = ex_mem_branch_target if taken, else 0.
- Statistics:
  - branch_count increments on each resolved B-type.
  - mispredict_count increments when ex_mem_predicted != ex_mem_branch_taken.
  - Both saturate at all-ones and never wrap.
- Same cycle, same index for read and update: the read returns the pre-update contents. There is no bypass; the new state is visible the next cycle.
- i_bp_clear:
  - Clears all valid bits next edge and suppresses the table update that cycle.
  - Counters, tags and targets are left stale.
  - Statistics still count.
- Reset (async assert, while low):
  - All valid=0, counters=WEAK_NT, tags=0, targets=0, branch_count=0, mispredict_count=0.
  - Outputs prediction=0, branch_target=0, bp_hit=0.
  - Reset mid-update: the update is lost; table holds reset values.
- Non-B-type ex_mem_opcode: no table or statistics change.

Decomposition:
- Shared package holds:
  - B_TYPE = 7'b1100011.
  - Counter encodings: STRONG_NT, WEAK_NT, WEAK_T, STRONG_T (for CNT_BITS=2).
  - Index/tag slice helper functions.
- Sub-module bp_sat_counter: CNT_BITS-wide up/down saturating counter with load value and async reset to WEAK_NT, instantiated per entry.
- Statistics counters stay inline.

Test Plan:
- Reset: assert i_rst_n=0 mid-run, then release; B-type at if_pc=0x40 -> bp_hit=0, prediction=0, branch_target=0, both stat counters=0.
- Allocate: resolve B-type pc=0x40 taken, target=0x100. Next cycle, IF pc=0x40 -> bp_hit=1, prediction=1, branch_target=0x100, branch_count=1.
- Hysteresis and saturation:
  - pc=0x40 resolved taken 3 times (counter STRONG_T); then 1 not-taken -> prediction still 1.
  - A second not-taken -> prediction 0, branch_target=0.
- Aliasing: allocate pc=0x40, then resolve pc=0x40+(1<<(INDEX_BITS+2)) not-taken -> IF pc=0x40 gives bp_hit=0 (tag replaced).
- Simultaneous: IF pc=0x40 and EX/MEM allocate pc=0x40 in the same cycle -> that cycle bp_hit=0; next cycle bp_hit=1.
- Clear and statistics:
  - i_bp_clear=1 together with a B-type update -> all bp_hit=0 afterwards, table not written, branch_count still increments.
  - Force 2**PERF_WIDTH+3 mispredicts -> mispredict_count holds 0xFFFF.

Source files
------------

// File: rtl/branch_predictor_2bit_pkg.sv
// Shared definitions for the 2-bit branch predictor: opcode, counter encodings, PC slice helpers.
package branch_predictor_2bit_pkg;

  localparam logic [6:0] B_TYPE = 7'b1100011;

  // Encodings for the default 2-bit direction counter
  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  // Weakly-not-taken for an n-bit counter: 01..1
  function automatic logic [63:0] cnt_weak_nt(input int unsigned n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Weakly-taken for an n-bit counter: 10..0
  function automatic logic [63:0] cnt_weak_t(input int unsigned n);
    return 64'd1 << (n - 1);
  endfunction

  // Table index: pc[ib+1:2]
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned ib);
    return (pc >> 2) & ((64'd1 << ib) - 64'd1);
  endfunction

  // Partial tag: pc[ib+tb+1:ib+2]
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned ib,
                                         input int unsigned tb);
    return (pc >> (ib + 2)) & ((64'd1 << tb) - 64'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_2bit_if.sv
// Predictor bus: IF/ID lookup, EX/MEM resolution, clear, prediction and statistics.
//   master: pipeline side (drives lookup/resolution), slave: predictor.
interface branch_predictor_2bit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PERF_WIDTH = 16
);
  logic                  i_bp_clear;
  logic [6:0]            if_id_opcode;
  logic [DATA_WIDTH-1:0] if_pc;
  logic [6:0]            ex_mem_opcode;
  logic [DATA_WIDTH-1:0] ex_mem_pc;
  logic                  ex_mem_branch_taken;
  logic [DATA_WIDTH-1:0] ex_mem_branch_target;
  logic                  ex_mem_predicted;
  logic                  prediction;
  logic [DATA_WIDTH-1:0] branch_target;
  logic                  bp_hit;
  logic [PERF_WIDTH-1:0] branch_count;
  logic [PERF_WIDTH-1:0] mispredict_count;

  modport master (
    output i_bp_clear, if_id_opcode, if_pc, ex_mem_opcode, ex_mem_pc,
           ex_mem_branch_taken, ex_mem_branch_target, ex_mem_predicted,
    input  prediction, branch_target, bp_hit, branch_count, mispredict_count
  );

  modport slave (
    input  i_bp_clear, if_id_opcode, if_pc, ex_mem_opcode, ex_mem_pc,
           ex_mem_branch_taken, ex_mem_branch_target, ex_mem_predicted,
    output prediction, branch_target, bp_hit, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_2bit_sat_counter.sv
// Up/down saturating direction counter with load; resets to weakly-not-taken.
//   i_load/i_load_val: overwrite (priority), i_inc/i_dec: step, o_cnt: current value.
module bp_sat_counter
  import branch_predictor_2bit_pkg::*;
#(
  parameter int unsigned CNT_BITS = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic [CNT_BITS-1:0] i_load_val,
  input  logic                i_inc,
  input  logic                i_dec,
  output logic [CNT_BITS-1:0] o_cnt
);
  localparam logic [CNT_BITS-1:0] L_WEAK_NT = CNT_BITS'(cnt_weak_nt(CNT_BITS));

  logic [CNT_BITS-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= L_WEAK_NT;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_BITS'(1);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_BITS'(1);
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/branch_predictor_2bit.sv
// Direct-mapped BTB with per-entry saturating direction counters, valid bits and partial tags.
//   i_clk/i_rst_n: clock, async active-low reset; bp: lookup, resolution, clear, outputs, stats.
//   Lookup is combinational and sees pre-update contents; updates land on the next edge.
module branch_predictor_2bit
  import branch_predictor_2bit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned TAG_BITS   = 8,
  parameter int unsigned CNT_BITS   = 2,
  parameter int unsigned PERF_WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  branch_predictor_2bit_if.slave bp
);
  localparam int unsigned DEPTH = 2 ** INDEX_BITS;
  localparam logic [CNT_BITS-1:0] L_WEAK_NT = CNT_BITS'(cnt_weak_nt(CNT_BITS));
  localparam logic [CNT_BITS-1:0] L_WEAK_T  = CNT_BITS'(cnt_weak_t(CNT_BITS));

  logic [DEPTH-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag    [DEPTH];
  logic [DATA_WIDTH-1:0] r_target [DEPTH];
  logic [CNT_BITS-1:0]   w_cnt    [DEPTH];
  logic [PERF_WIDTH-1:0] r_branch_count;
  logic [PERF_WIDTH-1:0] r_mispredict_count;

  logic [INDEX_BITS-1:0] w_if_idx, w_ex_idx;
  logic [TAG_BITS-1:0]   w_if_tag, w_ex_tag;
  logic                  w_ex_btype, w_upd, w_ex_hit, w_hit, w_pred;
  logic [CNT_BITS-1:0]   w_load_val;

  // Address slicing for both ports
  assign w_if_idx = INDEX_BITS'(pc_index(64'(bp.if_pc), INDEX_BITS));
  assign w_if_tag = TAG_BITS'(pc_tag(64'(bp.if_pc), INDEX_BITS, TAG_BITS));
  assign w_ex_idx = INDEX_BITS'(pc_index(64'(bp.ex_mem_pc), INDEX_BITS));
  assign w_ex_tag = TAG_BITS'(pc_tag(64'(bp.ex_mem_pc), INDEX_BITS, TAG_BITS));

  // Resolution side: clear takes precedence over the table write
  assign w_ex_btype = (bp.ex_mem_opcode == B_TYPE);
  assign w_upd      = w_ex_btype && !bp.i_bp_clear;
  assign w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_load_val = bp.ex_mem_branch_taken ? L_WEAK_T : L_WEAK_NT;

  // Lookup side
  assign w_hit = (bp.if_id_opcode == B_TYPE) && r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_pred = w_hit && w_cnt[w_if_idx][CNT_BITS-1];
  assign bp.bp_hit        = w_hit;
  assign bp.prediction    = w_pred;
  assign bp.branch_target = w_pred ? r_target[w_if_idx] : '0;

  // Per-entry direction counters: load on allocate, step on hit
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic w_sel;
    assign w_sel = (w_ex_idx == INDEX_BITS'(g));
    bp_sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_upd && !w_ex_hit && w_sel),
      .i_load_val (w_load_val),
      .i_inc      (w_upd && w_ex_hit && w_sel && bp.ex_mem_branch_taken),
      .i_dec      (w_upd && w_ex_hit && w_sel && !bp.ex_mem_branch_taken),
      .o_cnt      (w_cnt[g])
    );
  end

  // Valid/tag/target storage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid  <= '0;
      r_tag    <= '{default: '0};
      r_target <= '{default: '0};
    end else if (bp.i_bp_clear) begin
      r_valid <= '0;
    end else if (w_upd) begin
      if (!w_ex_hit) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= bp.ex_mem_branch_taken ? bp.ex_mem_branch_target : '0;
      end else if (bp.ex_mem_branch_taken) begin
        r_target[w_ex_idx] <= bp.ex_mem_branch_target;
      end
    end
  end

  // Saturating statistics; they count even while the table is being cleared
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_ex_btype) begin
      if (r_branch_count != '1) begin
        r_branch_count <= r_branch_count + PERF_WIDTH'(1);
      end
      if ((bp.ex_mem_predicted != bp.ex_mem_branch_taken) && (r_mispredict_count != '1)) begin
        r_mispredict_count <= r_mispredict_count + PERF_WIDTH'(1);
      end
    end
  end

  assign bp.branch_count     = r_branch_count;
  assign bp.mispredict_count = r_mispredict_count;
endmodule
